// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48A1 slice and its result-side logic.
package dsp_pkg;

    // OPMODE tag width carried alongside each result
    localparam int TAG_W = 8;

    // Slice P output width
    localparam int P_W = 48;

    // A0 -> A1 -> M -> P path with every register enabled; keep in step with the slice
    localparam int DEFAULT_LATENCY = 4;

    // One captured slice result
    typedef struct packed {
        logic [P_W-1:0]   p;
        logic             carryout;
        logic [TAG_W-1:0] tag;
    } dsp_result_t;

    // Signature fold: rotate left by one, then xor in the new P
    function automatic logic [P_W-1:0] sig_fold(input logic [P_W-1:0] sig,
                                                input logic [P_W-1:0] p);
        return {sig[P_W-2:0], sig[P_W-1]} ^ p;
    endfunction

endpackage

// File: rtl/dsp_result_fifo.sv
// First-word-fall-through FIFO of dsp_result_t with occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module dsp_result_fifo
    import dsp_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  dsp_result_t wr_data,
    output dsp_result_t rd_data,
    output logic [CW-1:0] count,
    output logic        full,
    output logic        empty
);

    dsp_result_t   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          empty_s;
    logic          full_s;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic [CW-1:0] count_nxt_s;

    // Accept/pop qualification and next occupancy
    always_comb begin
        empty_s     = (count_r == {CW{1'b0}});
        full_s      = (count_r == CW'(DEPTH));
        pop_ok_s    = pop & ~empty_s;
        push_ok_s   = push & (~full_s | pop_ok_s);
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy; flush empties without touching storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = full_s;
    assign empty   = empty_s;

endmodule

// File: rtl/dsp_result_capture.sv
// Captures DSP48A1 slice results through a latency-matched valid/tag delay
// line, queues them in an FWFT FIFO and folds accepted P values into a
// running signature.
module dsp_result_capture
    import dsp_pkg::*;
#(
    parameter  int LATENCY = DEFAULT_LATENCY,
    parameter  int DEPTH   = 8,
    parameter  int PW      = P_W,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    input  logic [TAG_W-1:0] IN_TAG,
    input  logic             FLUSH,
    input  logic [PW-1:0]    P,
    input  logic             CARRYOUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [PW-1:0]    OUT_P,
    output logic             OUT_CARRYOUT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic [CW-1:0]    COUNT,
    output logic             OVERFLOW,
    output logic [PW-1:0]    SIGNATURE
);

    logic [LATENCY-1:0] dl_valid_r;
    logic [TAG_W-1:0]   dl_tag_r [LATENCY];
    logic               overflow_r;
    logic [PW-1:0]      signature_r;

    logic               push_req_s;
    logic               pop_s;
    logic               push_accept_s;
    logic               push_drop_s;
    dsp_result_t        wr_data_s;
    dsp_result_t        rd_data_s;
    logic [CW-1:0]      fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    // Delay line: valids die on flush so in-flight results never push
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dl_valid_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                dl_tag_r[i] <= {TAG_W{1'b0}};
            end
        end else begin
            dl_valid_r[0] <= IN_VALID & ~FLUSH;
            dl_tag_r[0]   <= IN_TAG;
            for (int i = 1; i < LATENCY; i++) begin
                dl_valid_r[i] <= dl_valid_r[i-1] & ~FLUSH;
                dl_tag_r[i]   <= dl_tag_r[i-1];
            end
        end
    end

    // Push/pop decisions and the entry presented to the FIFO
    always_comb begin
        push_req_s         = dl_valid_r[LATENCY-1];
        pop_s              = OUT_READY & ~fifo_empty_s;
        push_accept_s      = push_req_s & (~fifo_full_s | pop_s);
        push_drop_s        = push_req_s & fifo_full_s & ~pop_s;
        wr_data_s.p        = P;
        wr_data_s.carryout = CARRYOUT;
        wr_data_s.tag      = dl_tag_r[LATENCY-1];
    end

    dsp_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .flush   (FLUSH),
        .push    (push_req_s),
        .pop     (pop_s),
        .wr_data (wr_data_s),
        .rd_data (rd_data_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Sticky overflow and running signature; dropped results leave the signature alone
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow_r  <= 1'b0;
            signature_r <= {PW{1'b0}};
        end else if (FLUSH) begin
            overflow_r  <= 1'b0;
            signature_r <= {PW{1'b0}};
        end else begin
            if (push_drop_s) begin
                overflow_r <= 1'b1;
            end
            if (push_accept_s) begin
                signature_r <= sig_fold(signature_r, P);
            end
        end
    end

    assign OUT_VALID    = ~fifo_empty_s;
    assign OUT_P        = rd_data_s.p;
    assign OUT_CARRYOUT = rd_data_s.carryout;
    assign OUT_TAG      = rd_data_s.tag;
    assign COUNT        = fifo_count_s;
    assign OVERFLOW     = overflow_r;
    assign SIGNATURE    = signature_r;

endmodule
